// File: rtl/tis_pkg.sv
// TIS-100 style node: shared opcodes, selects and state types.
// Field offsets are expressed as functions of the data width.
package tis_pkg;

  localparam logic [3:0] OP_NOP = 4'd0;
  localparam logic [3:0] OP_MOV = 4'd1;
  localparam logic [3:0] OP_SWP = 4'd2;
  localparam logic [3:0] OP_SAV = 4'd3;
  localparam logic [3:0] OP_ADD = 4'd4;
  localparam logic [3:0] OP_SUB = 4'd5;
  localparam logic [3:0] OP_NEG = 4'd6;
  localparam logic [3:0] OP_JMP = 4'd7;
  localparam logic [3:0] OP_JEZ = 4'd8;
  localparam logic [3:0] OP_JNZ = 4'd9;
  localparam logic [3:0] OP_JGZ = 4'd10;
  localparam logic [3:0] OP_JLZ = 4'd11;
  localparam logic [3:0] OP_JRO = 4'd12;
  localparam logic [3:0] OP_HLT = 4'd13;

  localparam logic [3:0] SEL_ACC = 4'd0;
  localparam logic [3:0] SEL_NIL = 4'd1;
  localparam logic [3:0] SEL_IMM = 4'd2;

  typedef enum logic [1:0] {
    ST_EXEC,
    ST_RD_WAIT,
    ST_WR_WAIT,
    ST_HALT
  } state_t;

  typedef enum logic [1:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_NEG
  } alu_op_t;

  function automatic int op_lsb(int dw);
    return dw + 8;
  endfunction

  function automatic int src_lsb(int dw);
    return dw + 4;
  endfunction

  function automatic int dst_lsb(int dw);
    return dw;
  endfunction

endpackage

// File: rtl/tis_alu_sat.sv
// Saturating ADD/SUB/NEG on signed DW-bit words.
// Flags describe the A operand (the accumulator).
module tis_alu_sat
  import tis_pkg::*;
#(
  parameter int DW = 8
) (
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  input  alu_op_t       mode,
  output logic [DW-1:0] y,
  output logic          zero,
  output logic          pos,
  output logic          neg
);

  logic signed [DW:0] ax;
  logic signed [DW:0] bx;
  logic signed [DW:0] r;

  assign ax = {a[DW-1], a};
  assign bx = {b[DW-1], b};

  // one guard bit; overflow when it disagrees with the sign bit
  always_comb begin
    r = ax + bx;
    case (mode)
      ALU_SUB: r = ax - bx;
      ALU_NEG: r = -ax;
      default: r = ax + bx;
    endcase
    y = r[DW-1:0];
    if (r[DW] != r[DW-1])
      y = r[DW] ? {1'b1, {(DW-1){1'b0}}}
                : {1'b0, {(DW-1){1'b1}}};
  end

  assign zero = (a == '0);
  assign neg  = a[DW-1];
  assign pos  = !zero && !neg;

endmodule

// File: rtl/tis_node_core.sv
// Single compute node: ACC/BAK, saturating ALU, jumps and
// blocking neighbour channels over valid/response handshakes.
module tis_node_core
  import tis_pkg::*;
#(
  parameter int DW    = 8,
  parameter int NPORT = 4,
  parameter int AW    = 8,
  parameter int PLEN  = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [11+DW:0]      instr,
  output logic [AW-1:0]       iaddr,
  input  logic [NPORT*DW-1:0] in_data,
  input  logic [NPORT-1:0]    rrdy,
  output logic [NPORT-1:0]    rresp,
  output logic [NPORT*DW-1:0] out_data,
  output logic [NPORT-1:0]    val,
  input  logic [NPORT-1:0]    wresp,
  output logic [DW-1:0]       acc,
  output logic                stall,
  output logic                halted
);

  localparam int XW = AW + DW + 2;
  localparam logic [AW-1:0] PC_LAST = AW'(PLEN - 1);

  state_t state, state_n;

  logic [AW-1:0] pc, pc_inc, pc_jmp, pc_jro, pc_next, jt;
  logic [DW-1:0] bak, imm, src_val, rd_word, alu_y;
  logic [3:0]    op, src, dst;
  logic [2:0]    rk, wk;
  logic          src_port, dst_port, reads_src;
  logic          rd_req, wr_req, rd_rdy, wr_ack;
  logic          in_rd, go, retire_op, wr_done;
  logic          zero, pos, neg;
  alu_op_t       alu_mode;
  logic signed [XW-1:0] jsum;

  assign op  = instr[op_lsb(DW) +: 4];
  assign src = instr[src_lsb(DW) +: 4];
  assign dst = instr[dst_lsb(DW) +: 4];
  assign imm = instr[DW-1:0];
  assign rk  = src[2:0];
  assign wk  = dst[2:0];

  assign src_port = src[3] && (32'(rk) < NPORT);
  assign dst_port = dst[3] && (32'(wk) < NPORT);
  assign reads_src = (op == OP_MOV) || (op == OP_ADD)
                  || (op == OP_SUB) || (op == OP_JRO);
  assign rd_req = reads_src && src_port;
  assign wr_req = (op == OP_MOV) && dst_port;

  // per-port read/accept muxes
  always_comb begin
    rd_rdy  = 1'b0;
    rd_word = '0;
    wr_ack  = 1'b0;
    for (int i = 0; i < NPORT; i++) begin
      if (rk == 3'(i)) begin
        rd_rdy  = rrdy[i];
        rd_word = in_data[i*DW +: DW];
      end
      if (wk == 3'(i))
        wr_ack = wresp[i];
    end
  end

  // source operand select
  always_comb begin
    src_val = '0;
    unique case (1'b1)
      src_port:          src_val = rd_word;
      (src == SEL_ACC):  src_val = acc;
      (src == SEL_IMM):  src_val = imm;
      default:           src_val = '0;
    endcase
  end

  assign in_rd = ((state == ST_EXEC) || (state == ST_RD_WAIT)) && rd_req;
  assign go = ((state == ST_EXEC) && (!rd_req || rd_rdy))
           || ((state == ST_RD_WAIT) && rd_rdy);
  assign retire_op = go && !wr_req && (op != OP_HLT);
  assign wr_done = (state == ST_WR_WAIT) && wr_ack;

  assign alu_mode = (op == OP_SUB) ? ALU_SUB
                  : (op == OP_NEG) ? ALU_NEG : ALU_ADD;

  tis_alu_sat #(.DW(DW)) u_alu (
    .a    (acc),
    .b    (src_val),
    .mode (alu_mode),
    .y    (alu_y),
    .zero (zero),
    .pos  (pos),
    .neg  (neg)
  );

  assign pc_inc = (pc == PC_LAST) ? '0 : pc + AW'(1);
  assign jt     = AW'(imm);
  assign pc_jmp = (32'(jt) >= PLEN) ? '0 : jt;
  assign jsum   = XW'($signed({1'b0, pc})) + XW'($signed(src_val));
  assign pc_jro = (jsum < 0) ? '0
                : (jsum > XW'(PLEN - 1)) ? PC_LAST
                : jsum[AW-1:0];

  // branch resolution on the current ACC flags
  always_comb begin
    pc_next = pc_inc;
    case (op)
      OP_JMP: pc_next = pc_jmp;
      OP_JEZ: pc_next = zero ? pc_jmp : pc_inc;
      OP_JNZ: pc_next = !zero ? pc_jmp : pc_inc;
      OP_JGZ: pc_next = pos ? pc_jmp : pc_inc;
      OP_JLZ: pc_next = neg ? pc_jmp : pc_inc;
      OP_JRO: pc_next = pc_jro;
      default: pc_next = pc_inc;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) state <= ST_EXEC;
    else     state <= state_n;
  end

  // FSM next state
  always_comb begin
    state_n = state;
    case (state)
      ST_EXEC: begin
        if (rd_req && !rd_rdy)  state_n = ST_RD_WAIT;
        else if (wr_req)        state_n = ST_WR_WAIT;
        else if (op == OP_HLT)  state_n = ST_HALT;
      end
      ST_RD_WAIT:
        if (rd_rdy) state_n = wr_req ? ST_WR_WAIT : ST_EXEC;
      ST_WR_WAIT:
        if (wr_ack) state_n = ST_EXEC;
      default: state_n = ST_HALT;
    endcase
  end

  // FSM outputs; no consume pulse while reset is asserted
  always_comb begin
    rresp = '0;
    for (int i = 0; i < NPORT; i++)
      if (in_rd && !rst && (rk == 3'(i)))
        rresp[i] = rrdy[i];
    stall  = (state == ST_RD_WAIT) || (state == ST_WR_WAIT);
    halted = (state == ST_HALT);
  end

  // PC, ACC/BAK and write-channel registers
  always_ff @(posedge clk) begin
    if (rst) begin
      pc       <= '0;
      acc      <= '0;
      bak      <= '0;
      val      <= '0;
      out_data <= '0;
    end else begin
      if (retire_op) begin
        pc <= pc_next;
        case (op)
          OP_MOV: if (dst == SEL_ACC) acc <= src_val;
          OP_SWP: begin
            acc <= bak;
            bak <= acc;
          end
          OP_SAV: bak <= acc;
          OP_ADD, OP_SUB, OP_NEG: acc <= alu_y;
          default: ;
        endcase
      end
      if (go && wr_req)
        for (int i = 0; i < NPORT; i++)
          if (wk == 3'(i)) begin
            out_data[i*DW +: DW] <= src_val;
            val[i]               <= 1'b1;
          end
      if (wr_done) begin
        val <= '0;
        pc  <= pc_inc;
      end
    end
  end

  assign iaddr = pc;

endmodule

// File: tb/tb_tis_node_core.sv
// Bench for tis_node_core: directed scenarios plus random
// register/jump programs checked against an arithmetic model.
module tb_tis_node_core;

  localparam int DW = 8;
  localparam int NPORT = 4;
  localparam int AW = 8;
  localparam int PLEN = 6;

  logic        clk = 1'b0;
  logic        rst;
  logic [19:0] instr;
  logic [7:0]  iaddr;
  logic [31:0] in_data, out_data;
  logic [3:0]  rrdy, rresp, val, wresp;
  logic [7:0]  acc;
  logic        stall, halted;

  logic [19:0] prog [256];
  int vectors = 0;
  int miscompares = 0;

  assign instr = prog[iaddr];

  always #5 clk = ~clk;

  tis_node_core #(
    .DW(DW), .NPORT(NPORT), .AW(AW), .PLEN(PLEN)
  ) dut (
    .clk(clk), .rst(rst), .instr(instr), .iaddr(iaddr),
    .in_data(in_data), .rrdy(rrdy), .rresp(rresp),
    .out_data(out_data), .val(val), .wresp(wresp),
    .acc(acc), .stall(stall), .halted(halted)
  );

  function automatic logic [19:0] mk(int op, int s, int d, int im);
    return {4'(op), 4'(s), 4'(d), 8'(im)};
  endfunction

  function automatic int sat(int x);
    if (x > 127) return 127;
    if (x < -128) return -128;
    return x;
  endfunction

  task automatic clear_prog();
    for (int i = 0; i < 256; i++) prog[i] = 20'h0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    rrdy = '0;
    wresp = '0;
    in_data = '0;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    clear_prog();
    prog[0] = mk(1, 8, 0, 0);
    rst = 1'b1;
    rrdy = 4'hF;
    wresp = '0;
    in_data = '0;
    tick();
    tick();
    vectors++;
    if (rresp !== 4'h0) begin
      miscompares++;
      $display("FAIL reset_rresp got %h want 0", rresp);
    end
    vectors++;
    if ({val, stall, halted} !== 6'b0) begin
      miscompares++;
      $display("FAIL reset_flags got %b want 0", {val, stall, halted});
    end
    vectors++;
    if (iaddr !== 8'd0 || acc !== 8'd0) begin
      miscompares++;
      $display("FAIL reset_regs got pc=%0d acc=%h want 0", iaddr, acc);
    end
    rrdy = '0;
    rst = 1'b0;
  endtask

  task automatic test_saturate();
    int exp_acc [5] = '{100, 127, -127, -128, 127};
    clear_prog();
    prog[0] = mk(4, 2, 0, 100);
    prog[1] = mk(4, 2, 0, 100);
    prog[2] = mk(6, 0, 0, 0);
    prog[3] = mk(5, 2, 0, 1);
    prog[4] = mk(6, 0, 0, 0);
    do_reset();
    for (int k = 0; k < 5; k++) begin
      tick();
      vectors++;
      if (acc !== 8'(exp_acc[k])) begin
        miscompares++;
        $display("FAIL sat_step%0d got %h want %h", k, acc, 8'(exp_acc[k]));
      end
    end
    tick();
    vectors++;
    if (iaddr !== 8'd0) begin
      miscompares++;
      $display("FAIL pc_wrap got %0d want 0", iaddr);
    end
  endtask

  task automatic test_swap_jump();
    clear_prog();
    prog[0] = mk(1, 2, 0, 5);
    prog[1] = mk(3, 0, 0, 0);
    prog[2] = mk(5, 2, 0, 5);
    prog[3] = mk(2, 0, 0, 0);
    prog[4] = mk(8, 0, 0, 3);
    prog[5] = mk(9, 0, 0, 0);
    do_reset();
    tick(); tick(); tick();
    vectors++;
    if (acc !== 8'd0) begin
      miscompares++;
      $display("FAIL swp_sub got %h want 0", acc);
    end
    tick();
    vectors++;
    if (acc !== 8'd5) begin
      miscompares++;
      $display("FAIL swp_acc got %h want 5", acc);
    end
    tick();
    vectors++;
    if (iaddr !== 8'd5) begin
      miscompares++;
      $display("FAIL jez_not_taken got %0d want 5", iaddr);
    end
    tick();
    vectors++;
    if (iaddr !== 8'd0) begin
      miscompares++;
      $display("FAIL jnz_taken got %0d want 0", iaddr);
    end
  endtask

  task automatic test_read_stall();
    int st = 0, pulses = 0, other = 0;
    clear_prog();
    prog[0] = mk(1, 10, 0, 0);
    do_reset();
    for (int i = 0; i < 8; i++) begin
      rrdy[2] = (i == 3);
      in_data[23:16] = 8'h2A;
      @(negedge clk);
      if (stall) st++;
      if (rresp[2]) pulses++;
      if ((rresp & 4'b1011) != 0) other++;
      tick();
    end
    rrdy = '0;
    vectors++;
    if (st !== 3) begin
      miscompares++;
      $display("FAIL rd_stall_cycles got %0d want 3", st);
    end
    vectors++;
    if (pulses !== 1 || other !== 0) begin
      miscompares++;
      $display("FAIL rd_rresp got %0d/%0d want 1/0", pulses, other);
    end
    vectors++;
    if (acc !== 8'h2A) begin
      miscompares++;
      $display("FAIL rd_acc got %h want 2a", acc);
    end
  endtask

  task automatic test_write_stall();
    int vc = 0, first = -1;
    bit sched [8] = '{1, 1, 0, 0, 0, 1, 0, 0};
    clear_prog();
    prog[0] = mk(1, 2, 0, 8'hFD);
    prog[1] = mk(1, 0, 9, 0);
    do_reset();
    for (int i = 0; i < 8; i++) begin
      wresp[1] = sched[i];
      @(negedge clk);
      if (val[1]) begin
        vc++;
        vectors++;
        if (out_data[15:8] !== 8'hFD) begin
          miscompares++;
          $display("FAIL wr_data c%0d got %h want fd", i, out_data[15:8]);
        end
      end
      if ((val & 4'b1101) != 0) begin
        miscompares++;
        $display("FAIL wr_other_val got %b want 0", val);
      end
      if (iaddr == 8'd2 && first < 0) first = i;
      tick();
    end
    wresp = '0;
    vectors++;
    if (vc !== 4) begin
      miscompares++;
      $display("FAIL wr_val_cycles got %0d want 4", vc);
    end
    vectors++;
    if (first !== 6) begin
      miscompares++;
      $display("FAIL wr_retire_cycle got %0d want 6", first);
    end
  endtask

  task automatic test_port_to_port();
    int rp = 0, vc = 0;
    logic [7:0] d;
    d = 8'($urandom);
    clear_prog();
    prog[0] = mk(1, 8, 11, 0);
    do_reset();
    rrdy[0] = 1'b1;
    in_data[7:0] = d;
    wresp[3] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (rresp[0]) rp++;
      if (val[3]) begin
        vc++;
        vectors++;
        if (out_data[31:24] !== d) begin
          miscompares++;
          $display("FAIL p2p_data got %h want %h", out_data[31:24], d);
        end
      end
      tick();
    end
    rrdy = '0;
    wresp = '0;
    vectors++;
    if (rp !== 1 || vc !== 1) begin
      miscompares++;
      $display("FAIL p2p_handshake got rd=%0d wr=%0d want 1/1", rp, vc);
    end
    vectors++;
    if (iaddr !== 8'd3) begin
      miscompares++;
      $display("FAIL p2p_pc got %0d want 3", iaddr);
    end
  endtask

  task automatic test_jro_clamp();
    clear_prog();
    prog[2] = mk(12, 2, 0, 8'hF7);
    do_reset();
    tick(); tick();
    tick();
    vectors++;
    if (iaddr !== 8'd0) begin
      miscompares++;
      $display("FAIL jro_neg got %0d want 0", iaddr);
    end
    clear_prog();
    prog[0] = mk(12, 2, 0, 20);
    prog[5] = mk(7, 0, 0, 200);
    do_reset();
    tick();
    vectors++;
    if (iaddr !== 8'd5) begin
      miscompares++;
      $display("FAIL jro_pos got %0d want 5", iaddr);
    end
    tick();
    vectors++;
    if (iaddr !== 8'd0) begin
      miscompares++;
      $display("FAIL jmp_oob got %0d want 0", iaddr);
    end
  endtask

  task automatic test_reset_during_write();
    clear_prog();
    prog[0] = mk(1, 2, 8, 7);
    do_reset();
    tick();
    vectors++;
    if (val[0] !== 1'b1 || out_data[7:0] !== 8'd7 || stall !== 1'b1) begin
      miscompares++;
      $display("FAIL rstw_pre got val=%b d=%h st=%b want 1/07/1",
               val[0], out_data[7:0], stall);
    end
    tick();
    rst = 1'b1;
    tick();
    vectors++;
    if (val !== 4'h0 || iaddr !== 8'd0 || stall !== 1'b0) begin
      miscompares++;
      $display("FAIL rstw_post got val=%h pc=%0d st=%b want 0/0/0",
               val, iaddr, stall);
    end
    rst = 1'b0;
  endtask

  task automatic test_halt();
    clear_prog();
    prog[1] = mk(13, 0, 0, 0);
    do_reset();
    tick();
    vectors++;
    if (halted !== 1'b0) begin
      miscompares++;
      $display("FAIL halt_early got %b want 0", halted);
    end
    tick();
    vectors++;
    if (halted !== 1'b1 || iaddr !== 8'd1) begin
      miscompares++;
      $display("FAIL halt_enter got h=%b pc=%0d want 1/1", halted, iaddr);
    end
    repeat (5) tick();
    vectors++;
    if (halted !== 1'b1 || iaddr !== 8'd1) begin
      miscompares++;
      $display("FAIL halt_hold got h=%b pc=%0d want 1/1", halted, iaddr);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    vectors++;
    if (halted !== 1'b0 || iaddr !== 8'd0) begin
      miscompares++;
      $display("FAIL halt_clear got h=%b pc=%0d want 0/0", halted, iaddr);
    end
  endtask

  task automatic test_random();
    int ops [15] = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12, 14, 15};
    int srcs [5] = '{0, 1, 2, 3, 13};
    int dsts [3] = '{0, 1, 14};
    int mpc, macc, mbak, sv, t, op, s, d, im, nxt;
    logic [19:0] w;
    for (int p = 0; p < 10; p++) begin
      clear_prog();
      for (int a = 0; a < PLEN; a++) begin
        im = ($urandom_range(0, 1) == 0) ? $urandom_range(0, 7)
                                         : $urandom_range(0, 255);
        prog[a] = mk(ops[$urandom_range(0, 14)],
                     srcs[$urandom_range(0, 4)],
                     dsts[$urandom_range(0, 2)], im);
      end
      do_reset();
      mpc = 0; macc = 0; mbak = 0;
      for (int c = 0; c < 40; c++) begin
        w = prog[mpc];
        op = int'(w[19:16]);
        s = int'(w[15:12]);
        d = int'(w[11:8]);
        im = int'(w[7:0]);
        sv = (s == 0) ? macc : (s == 2) ? int'($signed(w[7:0])) : 0;
        t = (im < PLEN) ? im : 0;
        nxt = (mpc == PLEN - 1) ? 0 : mpc + 1;
        case (op)
          1: if (d == 0) macc = sv;
          2: begin sv = macc; macc = mbak; mbak = sv; end
          3: mbak = macc;
          4: macc = sat(macc + sv);
          5: macc = sat(macc - sv);
          6: macc = sat(-macc);
          7: nxt = t;
          8: if (macc == 0) nxt = t;
          9: if (macc != 0) nxt = t;
          10: if (macc > 0) nxt = t;
          11: if (macc < 0) nxt = t;
          12: begin
            nxt = mpc + sv;
            if (nxt < 0) nxt = 0;
            if (nxt > PLEN - 1) nxt = PLEN - 1;
          end
          default: ;
        endcase
        mpc = nxt;
        tick();
        vectors++;
        if (iaddr !== 8'(mpc) || acc !== 8'(macc)) begin
          miscompares++;
          $display("FAIL rand_p%0d_c%0d got pc=%0d acc=%h want pc=%0d acc=%h",
                   p, c, iaddr, acc, mpc, 8'(macc));
        end
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    rrdy = '0;
    wresp = '0;
    in_data = '0;
    clear_prog();
    test_reset();
    test_saturate();
    test_swap_jump();
    test_read_stall();
    test_write_stall();
    test_port_to_port();
    test_jro_clamp();
    test_reset_during_write();
    test_halt();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

endmodule
